// File: rtl/image_pingpong_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : image_pingpong_ctrl_pkg
// Description : Shared constants and bank-state encoding for the image
//               ping-pong buffer, the UART image loader and the CNN engine.
// Revision    : 1.0 - initial release
// ============================================================================
package image_pingpong_ctrl_pkg;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 8;
  localparam int IMG_SIZE = 784;

  // Lifecycle of one image bank: loader fills a FREE bank, it becomes FULL,
  // the scheduler hands it to the engine (INFER), and eng_done frees it.
  typedef enum logic [1:0] {
    BANK_FREE  = 2'd0,
    BANK_FULL  = 2'd1,
    BANK_INFER = 2'd2
  } bank_state_e;

endpackage
`default_nettype wire

// File: rtl/image_bank_ram.sv
`default_nettype none
// ============================================================================
// Module      : image_bank_ram
// Description : Simple dual-port RAM holding one image. One write port and
//               one registered read port; read data holds when rd_en_i is low.
// Ports       : clk, wr_en_i/wr_addr_i/wr_data_i (write), rd_en_i/rd_addr_i
//               (read request), rd_data_o (registered read data).
// Revision    : 1.0 - initial release
// ============================================================================
module image_bank_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 784
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Callers guarantee addresses are below DEPTH whenever an enable is high.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/image_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : image_pingpong_ctrl
// Description : Double-buffered image store and inference scheduler between
//               the UART image loader (writer) and the CNN engine (reader).
//               Loader writes go to bank wb; completed banks are handed to the
//               engine with a one-cycle eng_start; eng_done recycles the bank.
// Ports       : clk, rst (sync, active-high)
//               loader : ld_wr_en/addr/data, ld_image_loaded, ld_bank_free
//               engine : eng_busy, eng_done, eng_start, eng_rd_en/addr/data,
//                        rd_bank
//               status : wr_overflow (sticky)
//               img_done_cnt/img_drop_cnt exist only when the macro
//               IMG_PINGPONG_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module image_pingpong_ctrl #(
  parameter int ADDR_W   = image_pingpong_ctrl_pkg::ADDR_W,
  parameter int DATA_W   = image_pingpong_ctrl_pkg::DATA_W,
  parameter int IMG_SIZE = image_pingpong_ctrl_pkg::IMG_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_wr_en,
  input  logic [ADDR_W-1:0] ld_wr_addr,
  input  logic [DATA_W-1:0] ld_wr_data,
  input  logic              ld_image_loaded,
  output logic              ld_bank_free,
  input  logic              eng_busy,
  input  logic              eng_done,
  output logic              eng_start,
  input  logic              eng_rd_en,
  input  logic [ADDR_W-1:0] eng_rd_addr,
  output logic [DATA_W-1:0] eng_rd_data,
  output logic              rd_bank,
  output logic              wr_overflow
`ifdef IMG_PINGPONG_STATS_EN
  ,
  output logic [15:0]       img_done_cnt,
  output logic [15:0]       img_drop_cnt
`endif
);

  import image_pingpong_ctrl_pkg::*;

  localparam logic [ADDR_W-1:0] IMG_LIMIT = ADDR_W'(IMG_SIZE);

  bank_state_e state_q [2];
  bank_state_e state_d [2];
  logic wb_q, wb_d, rb_q, rb_d;
  logic start_q, start_d;
  logic ovf_q, ovf_d;
  logic rd_sel_q, rd_zero_q;

  logic wb_free, load_ok, done_ok, rb_full_now;
  logic wr_in_range, rd_in_range;
  logic [DATA_W-1:0] ram_rd_data [2];

  // --------------------------------------------------------------------------
  // Bank-state / scheduler next-state logic. The three possible updates
  // (load, done, start) always touch banks in mutually exclusive states, so
  // applying them in sequence to a copy of the state never loses one.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wb_d        = wb_q;
    rb_d        = rb_q;
    start_d     = 1'b0;
    ovf_d       = ovf_q;

    wr_in_range = (ld_wr_addr < IMG_LIMIT);
    rd_in_range = (eng_rd_addr < IMG_LIMIT);
    wb_free     = (state_q[wb_q] == BANK_FREE);
    load_ok     = ld_image_loaded & wb_free;
    done_ok     = eng_done & (state_q[rb_q] == BANK_INFER);
    // A bank completing this cycle counts as FULL already, which gives the
    // single-cycle image_loaded -> eng_start path when rb == wb.
    rb_full_now = (state_q[rb_q] == BANK_FULL) | (load_ok & (wb_q == rb_q));

    if ((ld_wr_en | ld_image_loaded) & ~wb_free) begin
      ovf_d = 1'b1;
    end

    if (load_ok) begin
      state_d[wb_q] = BANK_FULL;
      wb_d          = ~wb_q;
    end

    if (done_ok) begin
      state_d[rb_q] = BANK_FREE;
      rb_d          = ~rb_q;
    end

    // Evaluated against the current rb only, so a start for the other bank
    // follows eng_done by at least one idle cycle.
    if (rb_full_now & ~eng_busy & ~start_q) begin
      start_d       = 1'b1;
      state_d[rb_q] = BANK_INFER;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q[0] <= BANK_FREE;
      state_q[1] <= BANK_FREE;
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      start_q    <= 1'b0;
      ovf_q      <= 1'b0;
      rd_sel_q   <= 1'b0;
      rd_zero_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      wb_q       <= wb_d;
      rb_q       <= rb_d;
      start_q    <= start_d;
      ovf_q      <= ovf_d;
      // Remember which bank answered and whether the address was valid;
      // both hold with the RAM output when no read is requested.
      if (eng_rd_en) begin
        rd_sel_q  <= rb_q;
        rd_zero_q <= ~rd_in_range;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Image banks
  // --------------------------------------------------------------------------
  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic BANK_ID = 1'(b);

    image_bank_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (IMG_SIZE)
    ) u_ram (
      .clk       (clk),
      .wr_en_i   (ld_wr_en & wb_free & wr_in_range & (wb_q == BANK_ID)),
      .wr_addr_i (ld_wr_addr),
      .wr_data_i (ld_wr_data),
      .rd_en_i   (eng_rd_en & rd_in_range & (rb_q == BANK_ID)),
      .rd_addr_i (eng_rd_addr),
      .rd_data_o (ram_rd_data[b])
    );
  end

  assign eng_rd_data  = rd_zero_q ? '0 : ram_rd_data[rd_sel_q];
  assign eng_start    = start_q;
  assign rd_bank      = rb_q;
  assign ld_bank_free = wb_free;
  assign wr_overflow  = ovf_q;

`ifdef IMG_PINGPONG_STATS_EN
  logic [15:0] done_cnt_q, drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      done_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (done_ok && (done_cnt_q != 16'hFFFF)) begin
        done_cnt_q <= done_cnt_q + 16'd1;
      end
      if (ld_image_loaded && !wb_free && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign img_done_cnt = done_cnt_q;
  assign img_drop_cnt = drop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/image_pingpong_ctrl.md
Name: image_pingpong_ctrl

Overview:
Double-buffered image store and inference scheduler between the UART image loader (writer) and the CNN inference engine (reader).
- Owns two 784-byte image banks.
- Steers loader writes into the free bank and hands completed images to the engine with a start pulse.
- Recycles each bank when the engine signals done, so image N+1 can stream in over UART while image N is being classified.

Parameters:
ADDR_W, 10, pixel address width
DATA_W, 8, pixel width
IMG_SIZE, 784, pixels per image; addresses >= IMG_SIZE are ignored

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
ld_wr_en  in  1  loader pixel write strobe
ld_wr_addr  in  ADDR_W  loader pixel address
ld_wr_data  in  DATA_W  loader pixel value
ld_image_loaded  in  1  one-cycle pulse: current image complete
ld_bank_free  out  1  writer bank is FREE (loader may stream)
eng_busy  in  1  inference engine running
eng_done  in  1  one-cycle pulse: engine finished current image
eng_start  out  1  one-cycle pulse: begin inference on rd bank
eng_rd_en  in  1  engine pixel read strobe
eng_rd_addr  in  ADDR_W  engine pixel address
eng_rd_data  out  DATA_W  pixel from rd bank, 1-cycle latency
rd_bank  out  1  bank currently owned by engine
wr_overflow  out  1  sticky: write or image_loaded arrived with no free bank

Behaviour:
- Bank state per bank (2 bits): FREE, FULL, INFER. Pointers wb (writer bank) and rb (reader bank), 1 bit each.
- Reset values:
  - Both banks FREE; wb=0, rb=0.
  - eng_start=0, eng_rd_data=0, wr_overflow=0, ld_bank_free=1.
  - Reset mid-operation discards both images; no eng_start is issued for them.
- Writes:
  - If ld_wr_en, state[wb]==FREE and ld_wr_addr<IMG_SIZE, write bank wb in the same cycle.
  - If state[wb]!=FREE, drop the write and set wr_overflow.
  - An out-of-range address is silently ignored.
- Image complete:
  - On ld_image_loaded with state[wb]==FREE: state[wb]<=FULL and wb<=~wb, next cycle.
  - A write in the same cycle as ld_image_loaded lands in the old wb bank. The loader issues its final pixel write in the same cycle as image_loaded.
  - ld_image_loaded with state[wb]!=FREE is dropped and sets wr_overflow.
- Scheduler (registered):
  - If state[rb]==FULL, !eng_busy and no eng_start was issued in the previous cycle: eng_start<=1 for one cycle, state[rb]<=INFER.
  - Minimum latency is ld_image_loaded at cycle t → eng_start at t+1, when rb==wb_old and the engine is idle.
- Done:
  - On eng_done with state[rb]==INFER: state[rb]<=FREE, rb<=~rb.
  - eng_done in any other state is ignored.
- Simultaneous events:
  - ld_image_loaded and eng_done in one cycle: both take effect. They always target different banks, or the same bank with FULL→ and INFER→ updates that cannot collide, because wb bank is FREE while rb bank is INFER.
  - Merge the per-bank next-state updates explicitly.
  - eng_done and a start condition for the other bank in the same cycle: the start is evaluated against post-done rb the following cycle, so a minimum 1-cycle gap between done and start is required.
- Reads:
  - eng_rd_data <= bank[rb][eng_rd_addr] when eng_rd_en; holds its value otherwise.
  - Reads of addresses >= IMG_SIZE return 0.
- ld_bank_free = (state[wb]==FREE), combinational from registered state.

Optional Feature:
Macro: IMG_PINGPONG_STATS_EN.
- Defined: adds outputs img_done_cnt[15:0] and img_drop_cnt[15:0], both reset to 0 and saturating at 0xFFFF.
  - img_done_cnt increments on each accepted eng_done.
  - img_drop_cnt increments on each dropped ld_image_loaded.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package: bank-state encodings (FREE=2'd0, FULL=2'd1, INFER=2'd2), IMG_SIZE and ADDR_W constants, shared with image_loader and the engine.
- One sub-module, image_bank_ram: single 784×8 simple dual-port RAM (1 write port, 1 registered read port), instantiated twice.
- Bank muxing and the scheduler FSM stay in the top module.

Test Plan:
- Reset, then load pixels 0..783 = addr[7:0] and pulse ld_image_loaded with engine idle → eng_start one cycle later; rd_bank=0; eng_rd_addr=5 returns 0x05 next cycle; ld_bank_free=1 (bank 1).
- Engine busy on bank 0 while a second image (all 0xAA) loads into bank 1 → no eng_start until eng_done. Then eng_start 2 cycles after eng_done, rd_bank=1, read addr 100 = 0xAA.
- Both banks FULL/INFER, third image written → ld_bank_free=0, writes dropped, wr_overflow=1, bank contents unchanged.
- ld_image_loaded and eng_done in the same cycle → both banks update correctly; next image starts; no lost or duplicated eng_start.
- Assert rst mid-load (pixel 400) and mid-inference → all states FREE, eng_start never pulses for the old images, wr_overflow=0.
- With IMG_PINGPONG_STATS_EN: 3 completed images + 1 drop → img_done_cnt=3, img_drop_cnt=1.
